// File: rtl/tour_cmd_seq_if.sv
// Signal bundle linking tour_cmd_seq to the solver, the UART wrapper and the command processor.
// The sequencer itself uses the slave modport.
interface tour_cmd_seq_if #(
    parameter int IDX_W = 5
);
    logic             start_tour;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic [15:0]      cmd_UART;
    logic             cmd_rdy_UART;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic [7:0]       resp;

    modport slave (
        input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output mv_indx, cmd, cmd_rdy, resp
    );

    modport master (
        output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  mv_indx, cmd, cmd_rdy, resp
    );
endinterface

// File: rtl/tour_cmd_seq.sv
// Walks the solved knight's tour, splitting each L-move into a vertical and a
// horizontal command for the command processor; passes UART commands through when idle.
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    tour_cmd_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, VERT, V_WAIT, HORZ, H_WAIT} state_t;

    localparam logic [3:0]       OP_MOVE    = 4'b0010;
    localparam logic [3:0]       OP_FANFARE = 4'b0011;
    localparam logic [7:0]       HDG_N      = 8'h00;
    localparam logic [7:0]       HDG_W      = 8'h3F;
    localparam logic [7:0]       HDG_S      = 8'h7F;
    localparam logic [7:0]       HDG_E      = 8'hBF;
    localparam logic [7:0]       RESP_IDLE  = 8'hA5;
    localparam logic [7:0]       RESP_BUSY  = 8'h5A;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_MOVES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
    logic [15:0]      cmd_q, cmd_d;
    logic [15:0]      hcmd_q, hcmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic [7:0]       resp_q, resp_d;

    logic             enter_vert;
    logic             dec_valid;
    logic [7:0]       v_hdg, h_hdg;
    logic [3:0]       v_cnt, h_cnt;
    logic             usurp;

    // Lowest set bit wins; an all-zero move is reported as invalid.
    always_comb begin
        dec_valid = 1'b1;
        v_hdg     = HDG_N;
        v_cnt     = 4'd1;
        h_hdg     = HDG_E;
        h_cnt     = 4'd1;
        casez (bus.move)
            8'b???????1: begin v_hdg = HDG_N; v_cnt = 4'd2; h_hdg = HDG_E; h_cnt = 4'd1; end
            8'b??????10: begin v_hdg = HDG_N; v_cnt = 4'd2; h_hdg = HDG_W; h_cnt = 4'd1; end
            8'b?????100: begin v_hdg = HDG_N; v_cnt = 4'd1; h_hdg = HDG_W; h_cnt = 4'd2; end
            8'b????1000: begin v_hdg = HDG_S; v_cnt = 4'd1; h_hdg = HDG_W; h_cnt = 4'd2; end
            8'b???10000: begin v_hdg = HDG_S; v_cnt = 4'd2; h_hdg = HDG_W; h_cnt = 4'd1; end
            8'b??100000: begin v_hdg = HDG_S; v_cnt = 4'd2; h_hdg = HDG_E; h_cnt = 4'd1; end
            8'b?1000000: begin v_hdg = HDG_S; v_cnt = 4'd1; h_hdg = HDG_E; h_cnt = 4'd2; end
            8'b10000000: begin v_hdg = HDG_N; v_cnt = 4'd1; h_hdg = HDG_E; h_cnt = 4'd2; end
            default:     dec_valid = 1'b0;
        endcase
    end

    // Index update kept apart from the move decode so the solver lookup never loops back.
    always_comb begin
        mv_indx_d = mv_indx_q;
        case (state_q)
            IDLE:    if (bus.start_tour) mv_indx_d = '0;
            H_WAIT:  if (bus.send_resp && (mv_indx_q != LAST_IDX)) mv_indx_d = mv_indx_q + 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        hcmd_d     = hcmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        resp_d     = resp_q;
        enter_vert = 1'b0;
        case (state_q)
            IDLE: begin
                resp_d    = RESP_IDLE;
                cmd_rdy_d = 1'b0;
                if (bus.start_tour) enter_vert = 1'b1;
            end
            VERT: begin
                if (bus.clr_cmd_rdy) begin
                    state_d   = V_WAIT;
                    cmd_rdy_d = 1'b0;
                end
            end
            V_WAIT: begin
                if (bus.send_resp) begin
                    state_d   = HORZ;
                    cmd_d     = hcmd_q;
                    cmd_rdy_d = 1'b1;
                    resp_d    = RESP_BUSY;
                end
            end
            HORZ: begin
                if (bus.clr_cmd_rdy) begin
                    state_d   = H_WAIT;
                    cmd_rdy_d = 1'b0;
                end
            end
            H_WAIT: begin
                if (bus.send_resp) begin
                    if (mv_indx_q == LAST_IDX) begin
                        state_d = IDLE;
                        resp_d  = RESP_IDLE;
                    end else begin
                        enter_vert = 1'b1;
                        resp_d     = RESP_BUSY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // mv_indx already presents the next index, so move here belongs to the move being entered.
        if (enter_vert) begin
            if (dec_valid) begin
                state_d   = VERT;
                cmd_d     = {OP_MOVE, v_hdg, v_cnt};
                hcmd_d    = {OP_FANFARE, h_hdg, h_cnt};
                cmd_rdy_d = 1'b1;
            end else begin
                state_d   = IDLE;
                cmd_rdy_d = 1'b0;
                resp_d    = RESP_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
            cmd_q     <= '0;
            hcmd_q    <= '0;
            cmd_rdy_q <= 1'b0;
            resp_q    <= RESP_IDLE;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
            cmd_q     <= cmd_d;
            hcmd_q    <= hcmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            resp_q    <= resp_d;
        end
    end

    assign usurp       = (state_q != IDLE);
    assign bus.cmd     = usurp ? cmd_q : bus.cmd_UART;
    assign bus.cmd_rdy = usurp ? cmd_rdy_q : bus.cmd_rdy_UART;
    assign bus.resp    = resp_q;
    assign bus.mv_indx = mv_indx_d;
endmodule
